pe_config_frame_loader: RTL and testbench
=========================================

// Module: pe_config_frame_loader
// PURPOSE
// - Configuration stage directly upstream of the PE switch matrix: assembles streamed config frames into a
//   shadow store, then atomically commits them to the ConfigBits / ConfigBits_N buses that drive the mux selects.
// - Active config changes only at commit, so the switch matrix never sees a partially loaded routing.
// PARAMETERS
// - NoConfigBits     73  width of ConfigBits / ConfigBits_N (matches switch matrix)
// - FrameBitsPerRow  32  width of one config frame
// - NumFrames        derived localparam = ceil(NoConfigBits/FrameBitsPerRow) (3 at defaults); AW = max(1,clog2(NumFrames))
// PORTS
// - UserCLK       in   1                single clock, all state on rising edge
// - RST           in   1                reset, synchronous, active-high
// - FrameData     in   FrameBitsPerRow  frame payload
// - FrameAddr     in   AW               frame index; frame f covers bits [f*FrameBitsPerRow +: FrameBitsPerRow]
// - FrameValid    in   1                frame present
// - FrameLast     in   1                qualifies with FrameValid: final frame of this load
// - FrameReady    out  1                loader accepts a frame this cycle
// - ConfigBits    out  NoConfigBits     active configuration, registered
// - ConfigBits_N  out  NoConfigBits     registered bitwise complement of ConfigBits
// - ConfigDone    out  1                sticky: last commit succeeded
// - ConfigErr     out  1                sticky error flag
// BEHAVIOUR
// - Reset (RST=1 at edge): shadow=0, written-mask=0, ConfigBits=0, ConfigBits_N=all 1s, ConfigDone=0,
//   ConfigErr=0, state=IDLE; FrameReady=0 while RST high, 1 from first cycle after release.
// - FSM: IDLE -> LOAD on any accepted frame; LOAD -> COMMIT on accepted frame with FrameLast=1
//   (IDLE -> COMMIT directly if first frame has FrameLast); COMMIT -> IDLE after exactly one cycle.
// - FrameReady = 1 in IDLE and LOAD, 0 in COMMIT. Accept = FrameValid & FrameReady.
// - On accept with FrameAddr < NumFrames: shadow slice written, mask[FrameAddr] set; repeat address: last wins.
//   Bits of top frame beyond NoConfigBits are discarded.
// - On accept with FrameAddr >= NumFrames: frame dropped, ConfigErr<=1; FrameLast on it still enters COMMIT.
// - First accepted frame in IDLE clears ConfigDone.
// - COMMIT: if mask all 1s -> ConfigBits<=shadow, ConfigBits_N<=~shadow, ConfigDone<=1;
//   else ConfigBits unchanged, ConfigErr<=1. Mask cleared in both cases; shadow retained.
// - Latency: FrameLast accepted at edge k -> ConfigBits valid after edge k+1; next frame accepted earliest edge k+2.
// - ConfigErr clears only on reset. ConfigBits/_N never change except at COMMIT or reset.
// - Reset mid-load: partial shadow and mask discarded, active config returns to reset value.
// CONFIGURATION
// - CONFIG_READBACK_EN defined: extra ports RbAddr in AW, RbData out FrameBitsPerRow; RbData registered
//   (1-cycle latency) = active ConfigBits slice at RbAddr, zero-padded above NoConfigBits, 0 if RbAddr out of
//   range; RbData=0 in reset. Undefined: ports and logic absent; all other behaviour identical.
// STRUCTURE
// - Package pe_config_pkg: FRAME_BITS default, num_frames(width,frame) function, ldr_state_t enum
//   {IDLE,LOAD,COMMIT}.
// - One sub-module pe_config_shadow_bank: shadow register + written-mask, write port, all_written,
//   clear_mask; FSM and active registers stay in top.
// TESTING
// - Frames 0,1,2 (last on 2) with 0xDEADBEEF,0x12345678,0x000001FF -> ConfigBits=73'h1FF_12345678_DEADBEEF
//   one edge after last accept, ConfigBits_N = complement, ConfigDone=1, ConfigErr=0.
// - Frames 0,2 only, FrameLast on 2 -> ConfigBits unchanged from prior load, ConfigErr=1, ConfigDone=0.
// - FrameAddr=3 -> frame dropped, ConfigErr=1, FrameReady low only in COMMIT cycle after FrameLast.
// - Frame 1 written twice (0xAAAA, then 0x5555) then commit -> slice 1 = 0x5555; top frame 0xFFFFFFFF
//   loads only bits [72:64].
// - RST asserted mid-load after frame 0 -> ConfigBits=0, ConfigBits_N=all 1s; fresh full load then commits OK.
// - CONFIG_READBACK_EN: after first test, RbAddr=2 -> RbData=0x000001FF next cycle; RbAddr=3 -> 0.

Source files
------------

// File: rtl/pe_config_pkg.sv
// Shared state encoding and sizing helpers for the PE configuration frame loader.
package pe_config_pkg;

    localparam int FRAME_BITS = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } ldr_state_t;

    function automatic int num_frames(input int width, input int frame);
        return (width + frame - 1) / frame;
    endfunction

    function automatic int addr_bits(input int frames);
        return (frames <= 1) ? 1 : $clog2(frames);
    endfunction

endpackage

// File: rtl/pe_config_shadow_bank.sv
// Shadow store for partially loaded configuration plus a per-frame written mask.
// The store is padded to whole frames; bits above NoConfigBits never reach the output.
module pe_config_shadow_bank
    import pe_config_pkg::*;
#(
    parameter int NoConfigBits    = 73,
    parameter int FrameBitsPerRow = FRAME_BITS,
    parameter int NumFrames       = num_frames(NoConfigBits, FrameBitsPerRow),
    parameter int AW              = addr_bits(NumFrames)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [FrameBitsPerRow-1:0] wr_data,
    input  logic                       clear_mask,
    output logic [NoConfigBits-1:0]    shadow,
    output logic                       all_written
);

    localparam int StoreBits = NumFrames * FrameBitsPerRow;

    logic [StoreBits-1:0] store_q, store_d;
    logic [NumFrames-1:0] mask_q, mask_d;
    logic [NumFrames-1:0] hit_s;

    // Mask is cleared before the write is merged, so a same-cycle write still marks its frame.
    always_comb begin
        store_d = store_q;
        hit_s   = '0;
        for (int f = 0; f < NumFrames; f++) begin
            hit_s[f] = wr_en && (wr_addr == AW'(f));
            store_d[f*FrameBitsPerRow +: FrameBitsPerRow] =
                hit_s[f] ? wr_data : store_q[f*FrameBitsPerRow +: FrameBitsPerRow];
        end
        mask_d = (clear_mask ? {NumFrames{1'b0}} : mask_q) | hit_s;
    end

    // Shadow and mask state.
    always_ff @(posedge clk) begin
        if (rst) begin
            store_q <= '0;
            mask_q  <= '0;
        end else begin
            store_q <= store_d;
            mask_q  <= mask_d;
        end
    end

    assign shadow      = store_q[NoConfigBits-1:0];
    assign all_written = &mask_q;

endmodule

// File: rtl/pe_config_frame_loader.sv
// Assembles streamed config frames in a shadow bank and commits them atomically to ConfigBits/ConfigBits_N.
// Optional feature macro: CONFIG_READBACK_EN adds registered readback of the active configuration.
module pe_config_frame_loader
    import pe_config_pkg::*;
#(
    parameter int  NoConfigBits    = 73,
    parameter int  FrameBitsPerRow = FRAME_BITS,
    localparam int NumFrames       = num_frames(NoConfigBits, FrameBitsPerRow),
    localparam int AW              = addr_bits(NumFrames)
) (
    input  logic                       UserCLK,
    input  logic                       RST,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [AW-1:0]              FrameAddr,
    input  logic                       FrameValid,
    input  logic                       FrameLast,
    output logic                       FrameReady,
    output logic [NoConfigBits-1:0]    ConfigBits,
    output logic [NoConfigBits-1:0]    ConfigBits_N,
    output logic                       ConfigDone,
    output logic                       ConfigErr
`ifdef CONFIG_READBACK_EN
    ,
    input  logic [AW-1:0]              RbAddr,
    output logic [FrameBitsPerRow-1:0] RbData
`endif
);

    ldr_state_t state_q, state_d;
    logic                    frame_ready_q, frame_ready_d;
    logic [NoConfigBits-1:0] config_bits_q, config_bits_d;
    logic [NoConfigBits-1:0] config_bits_n_q, config_bits_n_d;
    logic                    config_done_q, config_done_d;
    logic                    config_err_q, config_err_d;

    logic                    accept_s;
    logic                    in_range_s;
    logic                    wr_en_s;
    logic                    clear_mask_s;
    logic                    all_written_s;
    logic [NoConfigBits-1:0] shadow_s;

    assign accept_s     = FrameValid && frame_ready_q;
    assign in_range_s   = ({1'b0, FrameAddr} < (AW + 1)'(NumFrames));
    assign wr_en_s      = accept_s && in_range_s;
    assign clear_mask_s = (state_q == COMMIT);

    pe_config_shadow_bank #(
        .NoConfigBits    (NoConfigBits),
        .FrameBitsPerRow (FrameBitsPerRow),
        .NumFrames       (NumFrames),
        .AW              (AW)
    ) u_shadow_bank (
        .clk         (UserCLK),
        .rst         (RST),
        .wr_en       (wr_en_s),
        .wr_addr     (FrameAddr),
        .wr_data     (FrameData),
        .clear_mask  (clear_mask_s),
        .shadow      (shadow_s),
        .all_written (all_written_s)
    );

    // Next-state and output logic; out-of-range frames are dropped but still flag an error.
    always_comb begin
        state_d         = state_q;
        config_bits_d   = config_bits_q;
        config_bits_n_d = config_bits_n_q;
        config_done_d   = config_done_q;
        config_err_d    = config_err_q | (accept_s & ~in_range_s);
        case (state_q)
            IDLE, LOAD: begin
                state_d       = accept_s ? (FrameLast ? COMMIT : LOAD) : state_q;
                config_done_d = (accept_s && (state_q == IDLE)) ? 1'b0 : config_done_q;
            end
            COMMIT: begin
                state_d         = IDLE;
                config_bits_d   = all_written_s ? shadow_s  : config_bits_q;
                config_bits_n_d = all_written_s ? ~shadow_s : config_bits_n_q;
                config_done_d   = all_written_s ? 1'b1      : config_done_q;
                config_err_d    = all_written_s ? config_err_q : 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        frame_ready_d = (state_d != COMMIT);
    end

    // FSM and registered outputs.
    always_ff @(posedge UserCLK) begin
        if (RST) begin
            state_q         <= IDLE;
            frame_ready_q   <= 1'b0;
            config_bits_q   <= '0;
            config_bits_n_q <= '1;
            config_done_q   <= 1'b0;
            config_err_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            frame_ready_q   <= frame_ready_d;
            config_bits_q   <= config_bits_d;
            config_bits_n_q <= config_bits_n_d;
            config_done_q   <= config_done_d;
            config_err_q    <= config_err_d;
        end
    end

    assign FrameReady   = frame_ready_q;
    assign ConfigBits   = config_bits_q;
    assign ConfigBits_N = config_bits_n_q;
    assign ConfigDone   = config_done_q;
    assign ConfigErr    = config_err_q;

`ifdef CONFIG_READBACK_EN
    localparam int PadBits = NumFrames * FrameBitsPerRow;

    logic [PadBits-1:0]         active_padded_s;
    logic [FrameBitsPerRow-1:0] rb_data_q, rb_data_d;

    assign active_padded_s = PadBits'(config_bits_q);

    // Select the addressed slice of the active configuration; unmatched addresses read zero.
    always_comb begin
        rb_data_d = '0;
        for (int f = 0; f < NumFrames; f++) begin
            rb_data_d = (RbAddr == AW'(f)) ? active_padded_s[f*FrameBitsPerRow +: FrameBitsPerRow]
                                           : rb_data_d;
        end
    end

    // Readback register.
    always_ff @(posedge UserCLK) begin
        if (RST) begin
            rb_data_q <= '0;
        end else begin
            rb_data_q <= rb_data_d;
        end
    end

    assign RbData = rb_data_q;
`endif

endmodule

// File: tb/tb_pe_config_frame_loader.sv
// Scoreboard bench for pe_config_frame_loader: each commit (or reset release) pushes its expected
// active configuration; a monitor pops and compares on every FrameReady rising transition.
module tb_pe_config_frame_loader;

    logic        UserCLK;
    logic        RST;
    logic [31:0] FrameData;
    logic [1:0]  FrameAddr;
    logic        FrameValid;
    logic        FrameLast;
    logic        FrameReady;
    logic [72:0] ConfigBits;
    logic [72:0] ConfigBits_N;
    logic        ConfigDone;
    logic        ConfigErr;
`ifdef CONFIG_READBACK_EN
    logic [1:0]  RbAddr;
    logic [31:0] RbData;
`endif

    pe_config_frame_loader dut (
        .UserCLK      (UserCLK),
        .RST          (RST),
        .FrameData    (FrameData),
        .FrameAddr    (FrameAddr),
        .FrameValid   (FrameValid),
        .FrameLast    (FrameLast),
        .FrameReady   (FrameReady),
        .ConfigBits   (ConfigBits),
        .ConfigBits_N (ConfigBits_N),
        .ConfigDone   (ConfigDone),
        .ConfigErr    (ConfigErr)
`ifdef CONFIG_READBACK_EN
        ,
        .RbAddr       (RbAddr),
        .RbData       (RbData)
`endif
    );

    typedef struct packed {
        logic [72:0] cfg;
        logic        done;
        logic        err;
        logic        from_reset;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          low_cnt = 0;
    logic        prev_ready = 1'b0;
    logic [72:0] last_cfg = 73'h0;
    exp_t        e;

    localparam logic [72:0] CFG_A     = 73'h1FF_12345678_DEADBEEF;
    localparam logic [72:0] CFG_OOR   = 73'h055_0BADC0DE_CAFEF00D;
    localparam logic [72:0] CFG_ONES  = 73'h1FF_FFFFFFFF_FFFFFFFF;
    localparam logic [72:0] CFG_FINAL = 73'h1FF_00005555_01234567;

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    task automatic chk(input string name, input logic [72:0] got, input logic [72:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic push_exp(input logic [72:0] cfg, input logic done, input logic err,
                            input logic from_reset);
        exp_t x;
        x.cfg        = cfg;
        x.done       = done;
        x.err        = err;
        x.from_reset = from_reset;
        exp_q.push_back(x);
    endtask

    task automatic send_frame(input logic [1:0] a, input logic [31:0] d, input logic l);
        int waited;
        waited = 0;
        @(negedge UserCLK);
        while (!FrameReady && waited < 20) begin
            @(negedge UserCLK);
            waited++;
        end
        if (!FrameReady) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got FrameReady=%0b expected 1 within 20 cycles", FrameReady);
        end
        FrameAddr  = a;
        FrameData  = d;
        FrameValid = 1'b1;
        FrameLast  = l;
        @(negedge UserCLK);
        FrameValid = 1'b0;
        FrameLast  = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge UserCLK);
        RST        = 1'b1;
        FrameValid = 1'b0;
        FrameLast  = 1'b0;
        repeat (2) @(negedge UserCLK);
        push_exp(73'h0, 1'b0, 1'b0, 1'b1);
        RST = 1'b0;
    endtask

    // Monitor: a FrameReady rise marks a finished commit or reset release; otherwise the active config must hold.
    always @(posedge UserCLK) begin
        #1;
        if (RST) begin
            prev_ready = 1'b0;
            low_cnt    = 0;
        end else begin
            if (FrameReady && !prev_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit: got ConfigBits=%h expected no commit", ConfigBits);
                end else begin
                    e = exp_q.pop_front();
                    chk("config_bits", ConfigBits, e.cfg);
                    chk("config_bits_n", ConfigBits_N, ~e.cfg);
                    chk("config_done", {72'h0, ConfigDone}, {72'h0, e.done});
                    chk("config_err", {72'h0, ConfigErr}, {72'h0, e.err});
                    if (!e.from_reset) begin
                        chk("commit_ready_low_cycles", 73'(low_cnt), 73'd1);
                    end
                    last_cfg = e.cfg;
                end
                low_cnt = 0;
            end else begin
                if (!FrameReady) low_cnt++;
                chk("config_bits_stable", ConfigBits, last_cfg);
                chk("config_bits_n_stable", ConfigBits_N, ~last_cfg);
            end
            prev_ready = FrameReady;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        RST        = 1'b1;
        FrameData  = 32'h0;
        FrameAddr  = 2'd0;
        FrameValid = 1'b0;
        FrameLast  = 1'b0;
`ifdef CONFIG_READBACK_EN
        RbAddr     = 2'd0;
`endif
        repeat (3) @(negedge UserCLK);
        push_exp(73'h0, 1'b0, 1'b0, 1'b1);
        RST = 1'b0;

        // Full load.
        send_frame(2'd0, 32'hDEADBEEF, 1'b0);
        send_frame(2'd1, 32'h12345678, 1'b0);
        send_frame(2'd2, 32'h000001FF, 1'b1);
        push_exp(CFG_A, 1'b1, 1'b0, 1'b0);

`ifdef CONFIG_READBACK_EN
        repeat (2) @(negedge UserCLK);
        RbAddr = 2'd2;
        @(posedge UserCLK);
        #1;
        chk("readback_addr2", {41'h0, RbData}, 73'h1FF);
        @(negedge UserCLK);
        RbAddr = 2'd3;
        @(posedge UserCLK);
        #1;
        chk("readback_addr3", {41'h0, RbData}, 73'h0);
        @(negedge UserCLK);
        RbAddr = 2'd0;
        @(posedge UserCLK);
        #1;
        chk("readback_addr0", {41'h0, RbData}, 73'hDEADBEEF);
`endif

        // Frame 1 missing: commit rejected.
        send_frame(2'd0, 32'h11111111, 1'b0);
        send_frame(2'd2, 32'h00000000, 1'b1);
        push_exp(CFG_A, 1'b0, 1'b1, 1'b0);

        reset_dut();

        // Out-of-range frame dropped but its FrameLast still commits.
        send_frame(2'd0, 32'hCAFEF00D, 1'b0);
        send_frame(2'd1, 32'h0BADC0DE, 1'b0);
        send_frame(2'd2, 32'h00000055, 1'b0);
        send_frame(2'd3, 32'hFFFFFFFF, 1'b1);
        push_exp(CFG_OOR, 1'b1, 1'b1, 1'b0);

        // Single last frame straight from IDLE: incomplete mask.
        send_frame(2'd1, 32'h00000000, 1'b1);
        push_exp(CFG_OOR, 1'b0, 1'b1, 1'b0);

        // All ones, error stays sticky.
        send_frame(2'd0, 32'hFFFFFFFF, 1'b0);
        send_frame(2'd1, 32'hFFFFFFFF, 1'b0);
        send_frame(2'd2, 32'hFFFFFFFF, 1'b1);
        push_exp(CFG_ONES, 1'b1, 1'b1, 1'b0);

        // Reset mid-load.
        send_frame(2'd0, 32'h22222222, 1'b0);
        reset_dut();

        // Repeat address (last wins) and top-frame truncation.
        send_frame(2'd2, 32'hFFFFFFFF, 1'b0);
        send_frame(2'd1, 32'h0000AAAA, 1'b0);
        send_frame(2'd1, 32'h00005555, 1'b0);
        send_frame(2'd0, 32'h01234567, 1'b1);
        push_exp(CFG_FINAL, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge UserCLK);
        repeat (3) @(negedge UserCLK);
        chk("scoreboard_drained", 73'(exp_q.size()), 73'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
